rv32v_lsc_lane_seq: RTL and testbench
=====================================

// Module: rv32v_lsc_lane_seq
// PURPOSE
//  Per-lane vector load/store sequencer between the RV32V execute stage and the single scalar data port.
//  Accepts one vector memory op (NUM_LANES addresses plus an active-lane mask) and issues one 32-bit bus access per active lane.
//  Lanes are serviced in ascending index order.
//  Loads are byte-steered and sign/zero-extended into a wide result. The block is generalised from the fixed-width LSC: lane count, bus wait and precise misalignment abort are all handled here.
// PARAMETERS
//  NUM_LANES  4  lanes per vector op; legal values are powers of 2 from 1 to 16. The lane-index type is $clog2(NUM_LANES) bits wide (1 bit minimum).
// PORTS
//  CLK             in   1            clock
//  RST             in   1            asynchronous reset, active-high
//  req_valid       in   1            vector op present; held with its fields until accepted
//  req_ready       out  1            high in IDLE only; the op is accepted when req_valid && req_ready
//  req_wen/req_ren in   1/1          store/load; exactly one is set when req_valid
//  req_load_type   in   load_t       LB/LH/LW/LBU/LHU; stores use the same size encoding
//  req_addr_wide   in   32*NUM_LANES per-lane byte address
//  req_store_wide  in   32*NUM_LANES per-lane store data, right-aligned
//  req_ven_lanes   in   NUM_LANES    active-lane mask
//  bus_ren/bus_wen out  1/1          scalar port strobes
//  bus_addr        out  32           word-aligned address ({addr[31:2],2'b0})
//  bus_wdata       out  32           store data, steered to its byte lane
//  bus_byte_en     out  4            byte enables
//  bus_busy        in   1            access incomplete; the access completes in the first cycle it is low
//  bus_rdata       in   32           load data, valid on completion
//  dload_ext_wide  out  32*NUM_LANES extended load results; registered per lane
//  lanes_done      out  NUM_LANES    lanes committed for the current op
//  done            out  1            1-cycle pulse when the op finishes (normal or abort)
//  mal_addr        out  1            set with done if the op aborted on misalignment; holds until next accept
//  mal_lane        out  lane idx     index of the faulting lane
// BEHAVIOUR
//  Reset: all outputs are 0, including dload_ext_wide, and the FSM returns to IDLE. Reset asserted mid-access drops bus_ren/bus_wen immediately.
//  Latched state: accept latches every req_* field.
//  Register pending: pending = ven_lanes & ~lanes_done.
//  lanes_done: cleared in the accept cycle; otherwise it holds its value until the next accept.
//  FSM states: IDLE, PICK, ACCESS, DONE.
//   IDLE goes to PICK on accept.
//   PICK selects the lowest pending lane L.
//    - If pending is 0, go to DONE.
//    - If L is misaligned (LH/LHU with a[0]=1, or LW with a[1:0]!=0), set mal_addr, set mal_lane=L, go to DONE. No bus access is made; L and all later lanes stay uncommitted.
//    - Otherwise go to ACCESS.
//   ACCESS drives the bus strobe, bus_addr, byte_en and wdata from L and holds them while bus_busy is high.
//    On the first cycle with !bus_busy: commit L by setting lanes_done[L]; for a load, write the extended bus_rdata into dload_ext_wide[L]. Then go to PICK.
//   DONE pulses done for one cycle, then goes to IDLE.
//  Latency: an op with k aligned lanes and zero wait states takes 2k+2 cycles from accept to done. Each bus wait cycle adds one cycle.
//  Byte steering:
//   - byte_en is 0001<<a[1:0] for byte, 0011<<a[1:0] for half, 1111 for word.
//   - wdata is store byte/half replicated across the word.
//   - The load extracts rdata >> (8*a[1:0]), then sign-extends (LB/LH) or zero-extends (LBU/LHU).
//  Unloaded lanes: dload_ext_wide for inactive, faulted and store lanes keeps its previous value.
//  req_valid during busy: ignored (req_ready=0).
// CONFIGURATION
//  RV32V_LSC_COALESCE_EN defined: load coalescing is enabled.
//   - On load completion for lane L, every pending lane M>L with the same addr[31:2] that is aligned is committed in the same cycle.
//   - Each such lane M is extracted from the same bus_rdata using its own a[1:0].
//   - Stores and misaligned lanes are never coalesced.
//   - A misaligned lane M>L is not committed and aborts on the next PICK.
//   - For example, a unit-stride LB over 4 lanes makes 1 bus access.
//  Not defined: every active lane makes its own access; there is no address compare logic.
// STRUCTURE
//  rv32v_types_pkg adds:
//   - lsc_seq_state_t (IDLE/PICK/ACCESS/DONE)
//   - lane_idx_t
//   - function lsc_byte_en(load_t, logic[1:0])
//   - function lsc_load_ext(load_t, logic[1:0], word_t)
//  Sub-module rv32v_lsc_lane_pick: combinational lowest-set-bit priority encoder with a found flag.
// TESTING
//  1. LW, mask 1111, addrs 0x100/104/108/10C, 0 wait -> 4 accesses in order; lanes_done=1111; done at cycle 10 after accept; mal_addr=0.
//  2. LB, mask 0101, addr lane2=0x203, rdata=0x80000000 -> lane0 and lane2 accessed; byte_en lane2=1000; dload[2]=0xFFFFFF80; lanes 1,3 unchanged.
//  3. LW, mask 1111, lane2 addr=0x302 -> lanes 0,1 accessed; done with mal_addr=1, mal_lane=2; lanes_done=0011; no access for lanes 2,3.
//  4. SH lane0 addr 0x402, data 0x0000BEEF, bus_busy high 3 cycles -> strobes held 4 cycles; byte_en=1100; wdata=0xBEEFBEEF; done 3 cycles later than zero-wait.
//  5. mask 0000 -> no bus strobe, done 2 cycles after accept; RST asserted during ACCESS -> bus_ren=0 same cycle, req_ready=1 after release.
//  6. COALESCE_EN: LBU, lanes 0x500..0x503, rdata=0x44332211 -> 1 access; dload={0x44,0x33,0x22,0x11} for lanes 3..0; disabled -> 4 accesses with the same results.

Source files
------------

// File: rtl/rv32v_types_pkg.sv
// rtl/rv32v_types_pkg.sv - shared types and byte-steering helpers for the RV32V LSC lane sequencer
package rv32v_types_pkg;

  typedef logic [31:0] word_t;

  // Load size/sign encoding; stores reuse the same size codes (SB=LB, SH=LH, SW=LW)
  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd4,
    LHU = 3'd5
  } load_t;

  typedef enum logic [1:0] {
    IDLE,
    PICK,
    ACCESS,
    DONE
  } lsc_seq_state_t;

  // Widest lane index needed for the largest legal lane count (16)
  localparam int LANE_IDX_MAX_W = 4;
  typedef logic [LANE_IDX_MAX_W-1:0] lane_idx_t;

  // Halfwords need an even address, words a 4-byte aligned one
  function automatic logic lsc_misaligned(load_t t, logic [1:0] off);
    case (t)
      LH, LHU: return off[0];
      LW:      return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lsc_byte_en(load_t t, logic [1:0] off);
    case (t)
      LB, LBU: return 4'b0001 << off;
      LH, LHU: return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the right-aligned store datum so every byte lane sees it
  function automatic word_t lsc_store_data(load_t t, word_t d);
    case (t)
      LB, LBU: return {4{d[7:0]}};
      LH, LHU: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic word_t lsc_load_ext(load_t t, logic [1:0] off, word_t rdata);
    word_t sh;
    sh = rdata >> {off, 3'b000};
    case (t)
      LB:      return {{24{sh[7]}}, sh[7:0]};
      LH:      return {{16{sh[15]}}, sh[15:0]};
      LBU:     return {24'd0, sh[7:0]};
      LHU:     return {16'd0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

endpackage

// File: rtl/rv32v_lsc_lane_pick.sv
// rtl/rv32v_lsc_lane_pick.sv - lowest-set-bit priority encoder with found flag
module rv32v_lsc_lane_pick #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan downward so the lowest set bit is the last one to win
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rv32v_lsc_lane_seq.sv
// rtl/rv32v_lsc_lane_seq.sv - per-lane vector load/store sequencer (option: RV32V_LSC_COALESCE_EN)
module rv32v_lsc_lane_seq
  import rv32v_types_pkg::*;
#(
  parameter  int NUM_LANES = 4,
  localparam int IDX_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wen,
  input  logic                    req_ren,
  input  load_t                   req_load_type,
  input  logic [32*NUM_LANES-1:0] req_addr_wide,
  input  logic [32*NUM_LANES-1:0] req_store_wide,
  input  logic [NUM_LANES-1:0]    req_ven_lanes,
  output logic                    bus_ren,
  output logic                    bus_wen,
  output logic [31:0]             bus_addr,
  output logic [31:0]             bus_wdata,
  output logic [3:0]              bus_byte_en,
  input  logic                    bus_busy,
  input  logic [31:0]             bus_rdata,
  output logic [32*NUM_LANES-1:0] dload_ext_wide,
  output logic [NUM_LANES-1:0]    lanes_done,
  output logic                    done,
  output logic                    mal_addr,
  output logic [IDX_W-1:0]        mal_lane
);

  lsc_seq_state_t       state, state_d;
  logic                 op_ren, op_wen;
  load_t                op_type;
  word_t                addr_q  [NUM_LANES];
  word_t                data_q  [NUM_LANES];
  word_t                dload_q [NUM_LANES];
  logic [NUM_LANES-1:0] ven_q, pending, commit;
  logic [IDX_W-1:0]     cur_lane, pick_idx;
  logic                 pick_found, pick_mal, accept;

  assign accept  = req_valid && req_ready;
  assign pending = ven_q & ~lanes_done;

  rv32v_lsc_lane_pick #(.N(NUM_LANES)) u_pick (
    .req   (pending),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign pick_mal = lsc_misaligned(op_type, addr_q[pick_idx][1:0]);

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_d;
  end

  // Next state: one bus access per committed lane, abort on a misaligned pick
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = PICK;
      PICK:    state_d = (!pick_found || pick_mal) ? DONE : ACCESS;
      ACCESS:  if (!bus_busy) state_d = PICK;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus strobes and steering are driven only while a lane is in ACCESS
  always_comb begin
    req_ready   = (state == IDLE) && !RST;
    done        = (state == DONE);
    bus_ren     = 1'b0;
    bus_wen     = 1'b0;
    bus_addr    = '0;
    bus_byte_en = '0;
    bus_wdata   = '0;
    if (state == ACCESS) begin
      bus_ren     = op_ren;
      bus_wen     = op_wen;
      bus_addr    = {addr_q[cur_lane][31:2], 2'b00};
      bus_byte_en = lsc_byte_en(op_type, addr_q[cur_lane][1:0]);
      bus_wdata   = lsc_store_data(op_type, data_q[cur_lane]);
    end
  end

  // Lanes committed on the completing access cycle (plus same-word loads when coalescing)
  always_comb begin
    commit = '0;
    if (state == ACCESS && !bus_busy) begin
      commit[cur_lane] = 1'b1;
`ifdef RV32V_LSC_COALESCE_EN
      if (op_ren) begin
        for (int m = 0; m < NUM_LANES; m++) begin
          if (pending[m] && m > int'(cur_lane) &&
              addr_q[m][31:2] == addr_q[cur_lane][31:2] &&
              !lsc_misaligned(op_type, addr_q[m][1:0]))
            commit[m] = 1'b1;
        end
      end
`endif
    end
  end

  // Op latching, lane selection, commit tracking and load result capture
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op_ren     <= 1'b0;
      op_wen     <= 1'b0;
      op_type    <= LB;
      ven_q      <= '0;
      lanes_done <= '0;
      cur_lane   <= '0;
      mal_addr   <= 1'b0;
      mal_lane   <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        addr_q[i]  <= '0;
        data_q[i]  <= '0;
        dload_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        op_ren     <= req_ren;
        op_wen     <= req_wen;
        op_type    <= req_load_type;
        ven_q      <= req_ven_lanes;
        lanes_done <= '0;
        mal_addr   <= 1'b0;
        mal_lane   <= '0;
        for (int i = 0; i < NUM_LANES; i++) begin
          addr_q[i] <= req_addr_wide[i*32 +: 32];
          data_q[i] <= req_store_wide[i*32 +: 32];
        end
      end else begin
        lanes_done <= lanes_done | commit;
      end
      if (state == PICK) begin
        cur_lane <= pick_idx;
        if (pick_found && pick_mal) begin
          mal_addr <= 1'b1;
          mal_lane <= pick_idx;
        end
      end
      for (int m = 0; m < NUM_LANES; m++) begin
        if (commit[m] && op_ren)
          dload_q[m] <= lsc_load_ext(op_type, addr_q[m][1:0], bus_rdata);
      end
    end
  end

  // Flatten per-lane results onto the wide output
  always_comb begin
    dload_ext_wide = '0;
    for (int i = 0; i < NUM_LANES; i++) dload_ext_wide[i*32 +: 32] = dload_q[i];
  end

endmodule

// File: tb/tb_rv32v_lsc_lane_seq.sv
// tb/tb_rv32v_lsc_lane_seq.sv - self-checking bench for rv32v_lsc_lane_seq
module tb_rv32v_lsc_lane_seq;
  import rv32v_types_pkg::*;

  localparam int NL = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          req_valid = 1'b0, req_ready, req_wen = 1'b0, req_ren = 1'b0;
  load_t         req_load_type = LB;
  logic [127:0]  req_addr_wide = '0, req_store_wide = '0;
  logic [3:0]    req_ven_lanes = '0;
  logic          bus_ren, bus_wen, bus_busy = 1'b0;
  logic [31:0]   bus_addr, bus_wdata, bus_rdata = '0;
  logic [3:0]    bus_byte_en;
  logic [127:0]  dload_ext_wide;
  logic [3:0]    lanes_done;
  logic          done, mal_addr;
  logic [1:0]    mal_lane;

  rv32v_lsc_lane_seq #(.NUM_LANES(NL)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_ren(req_ren),
    .req_load_type(req_load_type), .req_addr_wide(req_addr_wide),
    .req_store_wide(req_store_wide), .req_ven_lanes(req_ven_lanes),
    .bus_ren(bus_ren), .bus_wen(bus_wen), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_byte_en(bus_byte_en), .bus_busy(bus_busy), .bus_rdata(bus_rdata),
    .dload_ext_wide(dload_ext_wide), .lanes_done(lanes_done), .done(done),
    .mal_addr(mal_addr), .mal_lane(mal_lane)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        wr;
    logic [31:0] wdata;
  } acc_t;

  int          n_checks = 0;
  int          n_errors = 0;
  acc_t        exp_q[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] mdl_dload [NL];
  logic [31:0] op_addr [NL];
  logic [31:0] op_data [NL];
  int          wait_cycles = 0;
  int          acc_count = 0;
  int          strobe_cycles = 0;
  logic [3:0]  acc_last_be = '0;
  int          last_cycles = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---- behavioural model helpers ----
  function automatic int m_size(load_t t);
    if (t == LB || t == LBU) return 1;
    if (t == LW) return 4;
    return 2;
  endfunction

  function automatic logic m_mis(load_t t, logic [31:0] a);
    return (a % m_size(t)) != 0;
  endfunction

  function automatic logic [3:0] m_be(load_t t, logic [31:0] a);
    return 4'(((1 << m_size(t)) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_rep(load_t t, logic [31:0] d);
    int sz;
    logic [31:0] msk, w;
    sz  = m_size(t);
    msk = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 1);
    w   = '0;
    for (int k = 0; k < 4 / sz; k++) w = w | ((d & msk) << (8 * sz * k));
    return w;
  endfunction

  function automatic logic [31:0] m_ext(load_t t, logic [31:0] a, logic [31:0] w);
    int sz;
    longint v, lim;
    sz  = m_size(t);
    lim = longint'(1) << (8 * sz);
    v   = longint'(w >> (8 * (a % 4))) % lim;
    if ((t == LB || t == LH) && v >= lim / 2) v = v - lim;
    return v[31:0];
  endfunction

  function automatic logic [31:0] mem_rd(logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hC0DE_0000 | (a & 32'h0000_FFFF);
  endfunction

  // Bus responder and per-cycle access comparator
  always @(negedge CLK) begin
    if (RST) begin
      bus_busy = 1'b0;
      strobe_cycles = 0;
    end else if (bus_ren || bus_wen) begin
      strobe_cycles++;
      if (strobe_cycles <= wait_cycles) begin
        bus_busy = 1'b1;
      end else begin
        acc_t e;
        bus_busy      = 1'b0;
        strobe_cycles = 0;
        bus_rdata     = mem_rd(bus_addr);
        acc_count++;
        acc_last_be   = bus_byte_en;
        if (exp_q.size() == 0) begin
          check("unexpected_access", {bus_addr, 28'd0, bus_byte_en}, '0);
        end else begin
          e = exp_q.pop_front();
          check("acc_addr", bus_addr, e.addr);
          check("acc_be", bus_byte_en, e.be);
          check("acc_dir", {bus_wen, bus_ren}, {e.wr, ~e.wr});
          if (e.wr) check("acc_wdata", bus_wdata, e.wdata);
        end
      end
    end else begin
      bus_busy = 1'b0;
    end
  end

  task automatic run_op(input string nm, input load_t t, input logic wr,
                        input logic [3:0] mask, input int wt);
    logic [3:0]  pend, exp_ld;
    logic        exp_mal;
    int          exp_ml, n_acc, cyc, L;
    logic [31:0] w;
    acc_t        e;
    pend = mask; exp_ld = '0; exp_mal = 1'b0; exp_ml = 0; n_acc = 0;
    while (1) begin
      L = -1;
      for (int i = NL - 1; i >= 0; i--) if (pend[i]) L = i;
      if (L < 0) break;
      if (m_mis(t, op_addr[L])) begin
        exp_mal = 1'b1; exp_ml = L;
        break;
      end
      e.addr = op_addr[L] & 32'hFFFF_FFFC;
      e.be = m_be(t, op_addr[L]);
      e.wr = wr;
      e.wdata = m_rep(t, op_data[L]);
      exp_q.push_back(e);
      n_acc++;
      w = mem_rd(e.addr);
      exp_ld[L] = 1'b1; pend[L] = 1'b0;
      if (!wr) mdl_dload[L] = m_ext(t, op_addr[L], w);
`ifdef RV32V_LSC_COALESCE_EN
      if (!wr)
        for (int m = L + 1; m < NL; m++)
          if (pend[m] && (op_addr[m] >> 2) == (op_addr[L] >> 2) && !m_mis(t, op_addr[m])) begin
            exp_ld[m] = 1'b1; pend[m] = 1'b0;
            mdl_dload[m] = m_ext(t, op_addr[m], w);
          end
`endif
    end
    wait_cycles = wt;
    acc_count = 0;
    for (int i = 0; i < NL; i++) begin
      req_addr_wide[i*32 +: 32]  = op_addr[i];
      req_store_wide[i*32 +: 32] = op_data[i];
    end
    req_load_type = t; req_wen = wr; req_ren = ~wr; req_ven_lanes = mask;
    req_valid = 1'b1;
    check({nm, "_req_ready"}, req_ready, 1'b1);
    @(posedge CLK);
    #1 req_valid = 1'b0;
    cyc = 0;
    while (cyc < 300) begin
      @(negedge CLK);
      cyc++;
      if (done) break;
    end
    last_cycles = cyc;
    check({nm, "_done_seen"}, done, 1'b1);
    check({nm, "_latency"}, cyc, 2 * n_acc + 2 + n_acc * wt);
    check({nm, "_mal_addr"}, mal_addr, exp_mal);
    if (exp_mal) check({nm, "_mal_lane"}, mal_lane, exp_ml[1:0]);
    check({nm, "_lanes_done"}, lanes_done, exp_ld);
    for (int i = 0; i < NL; i++) check({nm, "_dload"}, dload_ext_wide[i*32 +: 32], mdl_dload[i]);
    check({nm, "_acc_count"}, acc_count, n_acc);
    check({nm, "_q_empty"}, exp_q.size(), 0);
    @(negedge CLK);
    check({nm, "_done_pulse"}, done, 1'b0);
    check({nm, "_ready_after"}, req_ready, 1'b1);
  endtask

  task automatic set_addrs(input logic [31:0] a0, a1, a2, a3);
    op_addr[0] = a0; op_addr[1] = a1; op_addr[2] = a2; op_addr[3] = a3;
    for (int i = 0; i < NL; i++) op_data[i] = '0;
  endtask

  initial begin
    for (int i = 0; i < NL; i++) mdl_dload[i] = '0;
    mem[32'h200] = 32'h8000_0000;
    mem[32'h500] = 32'h4433_2211;
    mem[32'h600] = 32'h8001_7FFF;
    repeat (2) @(negedge CLK);
    // Reset state
    check("rst_ready", req_ready, 1'b0);
    check("rst_bus", {bus_ren, bus_wen, bus_byte_en, bus_addr, bus_wdata}, '0);
    check("rst_status", {done, mal_addr, mal_lane, lanes_done}, '0);
    check("rst_dload", dload_ext_wide, '0);
    RST = 1'b0;
    @(negedge CLK);

    // 1: LW unit stride, four lanes
    set_addrs(32'h100, 32'h104, 32'h108, 32'h10C);
    run_op("t1", LW, 1'b0, 4'b1111, 0);
    check("t1_cycle10", last_cycles, 10);
    check("t1_lanes", lanes_done, 4'b1111);

    // 2: LB masked, sign-extended top byte
    set_addrs(32'h210, 32'h999, 32'h203, 32'h777);
    run_op("t2", LB, 1'b0, 4'b0101, 0);
    check("t2_be_lane2", acc_last_be, 4'b1000);
    check("t2_dload2", dload_ext_wide[95:64], 32'hFFFF_FF80);
    check("t2_dload0", dload_ext_wide[31:0], 32'h0000_0010);
    check("t2_dload1_kept", dload_ext_wide[63:32], 32'hC0DE_0104);
    check("t2_dload3_kept", dload_ext_wide[127:96], 32'hC0DE_010C);

    // 3: LW misaligned lane 2 aborts
    set_addrs(32'h300, 32'h304, 32'h302, 32'h30C);
    run_op("t3", LW, 1'b0, 4'b1111, 0);
    check("t3_mal", {mal_addr, mal_lane}, {1'b1, 2'd2});
    check("t3_lanes", lanes_done, 4'b0011);
    check("t3_acc", acc_count, 2);

    // 4: SH with three wait cycles
    set_addrs(32'h402, 32'h0, 32'h0, 32'h0);
    op_data[0] = 32'h0000_BEEF;
    run_op("t4", LH, 1'b1, 4'b0001, 3);
    check("t4_be", acc_last_be, 4'b1100);
    check("t4_latency", last_cycles, 7);

    // 5a: empty mask
    set_addrs(32'h0, 32'h0, 32'h0, 32'h0);
    run_op("t5", LW, 1'b0, 4'b0000, 0);
    check("t5_cycle2", last_cycles, 2);
    check("t5_acc", acc_count, 0);

    // 7: LH/LHU-style sign handling, lane 1 upper half, lane 3 lower half
    set_addrs(32'h0, 32'h602, 32'h0, 32'h600);
    run_op("t7", LH, 1'b0, 4'b1010, 1);
    check("t7_dload1", dload_ext_wide[63:32], 32'hFFFF_8001);
    check("t7_dload3", dload_ext_wide[127:96], 32'h0000_7FFF);

    // 6: LBU coalescing candidate
    set_addrs(32'h500, 32'h501, 32'h502, 32'h503);
    run_op("t6", LBU, 1'b0, 4'b1111, 0);
    check("t6_dload", dload_ext_wide, {32'h44, 32'h33, 32'h22, 32'h11});
`ifdef RV32V_LSC_COALESCE_EN
    check("t6_acc", acc_count, 1);
`else
    check("t6_acc", acc_count, 4);
`endif

    // 5b: reset in the middle of a stalled access
    set_addrs(32'h700, 32'h0, 32'h0, 32'h0);
    wait_cycles = 20;
    for (int i = 0; i < NL; i++) req_addr_wide[i*32 +: 32] = op_addr[i];
    req_load_type = LW; req_wen = 1'b0; req_ren = 1'b1; req_ven_lanes = 4'b0001;
    req_valid = 1'b1;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge CLK);
    check("t5r_strobe_on", bus_ren, 1'b1);
    #1 RST = 1'b1;
    #1;
    check("t5r_strobe_off", {bus_ren, bus_wen}, 2'b00);
    check("t5r_dload_clr", dload_ext_wide, '0);
    exp_q.delete();
    for (int i = 0; i < NL; i++) mdl_dload[i] = '0;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("t5r_ready", req_ready, 1'b1);
    check("t5r_lanes", lanes_done, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
